// File: rtl/elbeth_mem_pkg.sv
//------------------------------------------------------------------------------
// Module   : elbeth_mem_pkg
// Purpose  : Shared types, lane-mask constants and rw-legality check for the
//            ELBETH memory-port protocol.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package elbeth_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] RW_READ    = 4'b0000;
  localparam logic [3:0] RW_BYTE0   = 4'b0001;
  localparam logic [3:0] RW_BYTE1   = 4'b0010;
  localparam logic [3:0] RW_BYTE2   = 4'b0100;
  localparam logic [3:0] RW_BYTE3   = 4'b1000;
  localparam logic [3:0] RW_HALF_LO = 4'b0011;
  localparam logic [3:0] RW_HALF_HI = 4'b1100;
  localparam logic [3:0] RW_WORD    = 4'b1111;

  // Only naturally aligned byte, half-word and word lane masks are legal.
  function automatic logic rw_is_legal(input logic [3:0] rw);
    logic legal;
    case (rw)
      RW_READ, RW_BYTE0, RW_BYTE1, RW_BYTE2, RW_BYTE3,
      RW_HALF_LO, RW_HALF_HI, RW_WORD: legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

`default_nettype wire

// File: rtl/elbeth_mem_responder_if.sv
//------------------------------------------------------------------------------
// Module   : elbeth_mem_responder_if
// Purpose  : ELBETH memory-port bundle (request from master, response from slave).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface elbeth_mem_responder_if #(
  parameter int ADDR_WIDTH = 8
) ();

  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_rw;
  logic [31:0]           mem_rdata;
  logic                  mem_ready;
  logic                  mem_error;

  modport master (
    output mem_en, mem_addr, mem_wdata, mem_rw,
    input  mem_rdata, mem_ready, mem_error
  );

  modport slave (
    input  mem_en, mem_addr, mem_wdata, mem_rw,
    output mem_rdata, mem_ready, mem_error
  );

endinterface

`default_nettype wire

// File: rtl/elbeth_byte_ram.sv
//------------------------------------------------------------------------------
// Module   : elbeth_byte_ram
// Purpose  : 32-bit word array with per-byte-lane synchronous write and
//            combinational read. Contents are not reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module elbeth_byte_ram #(
  parameter int WORD_ADDR_WIDTH = 6
) (
  input  logic                       clk,
  input  logic [3:0]                 we,
  input  logic [WORD_ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]                wdata,
  input  logic [WORD_ADDR_WIDTH-1:0] raddr,
  output logic [31:0]                rdata
);

  localparam int c_depth = 2 ** WORD_ADDR_WIDTH;

  logic [31:0] r_mem [c_depth];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        r_mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/elbeth_mem_responder.sv
//------------------------------------------------------------------------------
// Module   : elbeth_mem_responder
// Purpose  : Wait-state memory responder for one ELBETH memory port. Optional
//            abort-on-drop behaviour is enabled by ELBETH_MEM_RESP_ABORT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module elbeth_mem_responder
  import elbeth_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  elbeth_mem_responder_if.slave mem
);

  localparam int         c_word_aw   = ADDR_WIDTH - 2;
  localparam logic [3:0] c_wait_init = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_count;
  logic [3:0]            w_count_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_rw;
  logic [31:0]           r_rdata;
  logic                  r_ready;
  logic                  r_error;

  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [31:0]           w_req_wdata;
  logic [3:0]            w_req_rw;
  logic                  w_illegal;
  logic                  w_enter_resp;
  logic [3:0]            w_we;
  logic [31:0]           w_ram_rdata;

  // In IDLE the live inputs are used so LATENCY=0 can respond on acceptance.
  always_comb begin
    w_req_addr  = r_addr;
    w_req_wdata = r_wdata;
    w_req_rw    = r_rw;
    if (r_state == ST_IDLE) begin
      w_req_addr  = mem.mem_addr;
      w_req_wdata = mem.mem_wdata;
      w_req_rw    = mem.mem_rw;
    end
  end

  assign w_illegal    = (w_req_addr[1:0] != 2'b00) || !rw_is_legal(w_req_rw);
  assign w_enter_resp = (w_state_nxt == ST_RESP);
  assign w_we         = (w_enter_resp && !w_illegal) ? w_req_rw : 4'b0000;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE: begin
        if (mem.mem_en) begin
          if (LATENCY == 0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_count_nxt = c_wait_init;
          end
        end
      end
      ST_WAIT: begin
`ifdef ELBETH_MEM_RESP_ABORT_EN
        if (!mem.mem_en) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = 4'd0;
        end else if (r_count == 4'd0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_count_nxt = r_count - 4'd1;
        end
`else
        if (r_count == 4'd0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_count_nxt = r_count - 4'd1;
        end
`endif
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_count <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rw    <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (r_state == ST_IDLE && mem.mem_en) begin
        r_addr  <= mem.mem_addr;
        r_wdata <= mem.mem_wdata;
        r_rw    <= mem.mem_rw;
      end
      r_ready <= w_enter_resp;
      r_error <= w_enter_resp && w_illegal;
      if (w_enter_resp) begin
        r_rdata <= (!w_illegal && w_req_rw == RW_READ) ? w_ram_rdata : 32'd0;
      end
    end
  end

  elbeth_byte_ram #(
    .WORD_ADDR_WIDTH (c_word_aw)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_req_addr[ADDR_WIDTH-1:2]),
    .wdata (w_req_wdata),
    .raddr (w_req_addr[ADDR_WIDTH-1:2]),
    .rdata (w_ram_rdata)
  );

  assign mem.mem_rdata = r_rdata;
  assign mem.mem_ready = r_ready;
  assign mem.mem_error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_elbeth_mem_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_elbeth_mem_responder
// Purpose  : Self-checking bench for elbeth_mem_responder against a word-array
//            reference model (LATENCY=2).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_elbeth_mem_responder;

  localparam int LAT = 2;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [31:0] model [64];
  logic [3:0]  legal_rw [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

  elbeth_mem_responder_if #(.ADDR_WIDTH(8)) bus ();

  elbeth_mem_responder #(
    .ADDR_WIDTH (8),
    .LATENCY    (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mem (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit model_legal(input logic [7:0] a, input logic [3:0] rw);
    return (a[1:0] == 2'b00) && (rw inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF});
  endfunction

  // Junk request fields while the DUT is busy; they must be ignored.
  task automatic drive_junk();
`ifdef ELBETH_MEM_RESP_ABORT_EN
    bus.mem_en = 1'b1;
`else
    bus.mem_en = 1'($urandom_range(0, 1));
`endif
    bus.mem_addr  = 8'($urandom);
    bus.mem_wdata = $urandom;
    bus.mem_rw    = 4'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the
  // response cycle with the request dropped.
  task automatic do_txn(input logic [7:0] addr, input logic [3:0] rw, input logic [31:0] wdata);
    bit          legal;
    int          w;
    logic [31:0] exp_rd;
    legal  = model_legal(addr, rw);
    w      = int'(addr[7:2]);
    exp_rd = (legal && rw == 4'h0) ? model[w] : 32'd0;
    bus.mem_en    = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_rw    = rw;
    @(posedge clk);
    if (legal) begin
      for (int i = 0; i < 4; i++) begin
        if (rw[i]) model[w][8*i +: 8] = wdata[8*i +: 8];
      end
    end
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      if (k < LAT) begin
        check_val("ready_during_wait", 32'(bus.mem_ready), 32'd0);
        drive_junk();
      end else begin
        check_val("ready_at_latency", 32'(bus.mem_ready), 32'd1);
        check_val("error_at_resp", 32'(bus.mem_error), legal ? 32'd0 : 32'd1);
        check_val("rdata_at_resp", bus.mem_rdata, exp_rd);
        bus.mem_en    = 1'b0;
        bus.mem_addr  = 8'($urandom);
        bus.mem_wdata = $urandom;
        bus.mem_rw    = 4'($urandom);
      end
    end
    @(negedge clk);
    check_val("ready_pulse_width", 32'(bus.mem_ready), 32'd0);
    check_val("error_without_ready", 32'(bus.mem_error), 32'd0);
    check_val("rdata_hold", bus.mem_rdata, exp_rd);
  endtask

  initial begin
    logic [7:0]  a;
    logic [3:0]  rw;
    n_vec = 0;
    n_err = 0;
    rst           = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_rw    = '0;

    repeat (2) @(negedge clk);
    check_val("reset_ready", 32'(bus.mem_ready), 32'd0);
    check_val("reset_error", 32'(bus.mem_error), 32'd0);
    check_val("reset_rdata", bus.mem_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Give every word a known value so later reads are predictable.
    for (int i = 0; i < 64; i++) do_txn(8'(i * 4), 4'hF, $urandom);

    do_txn(8'h1C, 4'hF, 32'hFFFFFFBA);
    do_txn(8'h1C, 4'h0, 32'h0);
    check_val("plan_read_1c", bus.mem_rdata, 32'hFFFFFFBA);

    do_txn(8'h08, 4'hF, 32'h11223344);
    do_txn(8'h08, 4'h2, 32'h0000AA00);
    do_txn(8'h08, 4'h0, 32'h0);
    check_val("plan_lane_merge", bus.mem_rdata, 32'h1122AA44);

    do_txn(8'h03, 4'h0, 32'h0);
    do_txn(8'h04, 4'h6, 32'h5A5A5A5A);
    do_txn(8'h04, 4'h0, 32'h0);

    // Held request: accepts every LATENCY+2 cycles.
    bus.mem_en    = 1'b1;
    bus.mem_addr  = 8'h00;
    bus.mem_rw    = 4'h0;
    bus.mem_wdata = 32'h0;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_val("held_en_ready", 32'(bus.mem_ready), ((k % (LAT + 2)) == LAT) ? 32'd1 : 32'd0);
      if ((k % (LAT + 2)) == LAT) check_val("held_en_rdata", bus.mem_rdata, model[0]);
      if (k == 11) bus.mem_en = 1'b0;
    end
    @(negedge clk);

    // Reset one cycle after accepting a write: the write must be dropped.
    do_txn(8'h1C, 4'h0, 32'h0);
    bus.mem_en    = 1'b1;
    bus.mem_addr  = 8'h10;
    bus.mem_rw    = 4'hF;
    bus.mem_wdata = ~model[4];
    @(posedge clk);
    bus.mem_rw    = 4'h0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("async_reset_ready", 32'(bus.mem_ready), 32'd0);
    check_val("async_reset_error", 32'(bus.mem_error), 32'd0);
    check_val("async_reset_rdata", bus.mem_rdata, 32'd0);
    bus.mem_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      check_val("no_ready_after_reset", 32'(bus.mem_ready), 32'd0);
    end
    do_txn(8'h10, 4'h0, 32'h0);

    // Request dropped while waiting.
    bus.mem_en    = 1'b1;
    bus.mem_addr  = 8'h14;
    bus.mem_rw    = 4'hF;
    bus.mem_wdata = ~model[5];
    @(posedge clk);
`ifndef ELBETH_MEM_RESP_ABORT_EN
    model[5] = bus.mem_wdata;
`endif
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
`ifdef ELBETH_MEM_RESP_ABORT_EN
      check_val("abort_no_ready", 32'(bus.mem_ready), 32'd0);
`else
      check_val("drop_en_ready", 32'(bus.mem_ready), (k == LAT) ? 32'd1 : 32'd0);
`endif
      bus.mem_en = 1'b0;
    end
    do_txn(8'h14, 4'h0, 32'h0);

    // Randomised traffic with idle gaps.
    for (int n = 0; n < 150; n++) begin
      a  = 8'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      rw = ($urandom_range(0, 1) == 1) ? legal_rw[$urandom_range(0, 7)] : 4'($urandom);
      do_txn(a, rw, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_val("idle_ready", 32'(bus.mem_ready), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
